dmc_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares the dual-bank (bank A / bank B) data memory controller between two independent masters.
- Accepts valid/ready read and write requests, drives one command per cycle onto the memory controller's command port, and tracks in-flight reads through a tag pipeline.
- Routes each read result back to the requester that issued it, after the controller's fixed read latency.
- Supports a drain request that quiesces the memory port and signals when no reads remain outstanding.

---
 rtl/dmc_pkg.sv | 23 ++
 rtl/dmc_arbiter_if.sv | 62 ++++++
 rtl/dmc_rd_tag_pipe.sv | 45 ++++
 rtl/dmc_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmc_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmc_pkg.sv
`default_nettype none
// ============================================================================
// dmc_pkg : shared types for the dual-bank memory controller arbiter
// Rev 1.0 : initial release
// ============================================================================
package dmc_pkg;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } dmc_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } dmc_tag_t;

endpackage
`default_nettype wire

// File: rtl/dmc_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmc_arbiter_if : requester, response, drain and memory-port signal bundle
// Rev 1.0 : initial release
// ============================================================================
interface dmc_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_we;
  logic          req0_bank;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;

  logic          req1_valid;
  logic          req1_ready;
  logic          req1_we;
  logic          req1_bank;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;

  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;

  logic          mem_select;
  logic          write_enable;
  logic [DW-1:0] data_ex;
  logic [AW-1:0] add_ex;
  logic [DW-1:0] mem_rdata;
  logic          mem_cmd_valid;

  logic          drain_req;
  logic          drain_done;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_we, req0_bank, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_bank, req1_addr, req1_wdata,
    input  mem_rdata, drain_req,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mem_select, write_enable, data_ex, add_ex, mem_cmd_valid,
    output drain_done
  );

  // Requester / controller side
  modport master (
    output req0_valid, req0_we, req0_bank, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_bank, req1_addr, req1_wdata,
    output mem_rdata, drain_req,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mem_select, write_enable, data_ex, add_ex, mem_cmd_valid,
    input  drain_done
  );

endinterface
`default_nettype wire

// File: rtl/dmc_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// dmc_rd_tag_pipe : shift register of in-flight read tags with flush and empty
// Rev 1.0 : initial release
// ============================================================================
module dmc_rd_tag_pipe
  import dmc_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  wire      clk,
  input  wire      rst_n,
  input  dmc_tag_t i_load,
  input  wire      i_flush,
  output dmc_tag_t o_tag,
  output logic     o_empty
);

  // One slot beyond RD_LAT holds the tag during the cycle mem_rdata is presented.
  localparam int DEPTH = RD_LAT + 1;

  dmc_tag_t r_stage [DEPTH];
  logic     w_any_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_load;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    w_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_any_valid = w_any_valid | r_stage[i].valid;
  end

  assign o_tag   = r_stage[DEPTH-1];
  assign o_empty = ~w_any_valid;

endmodule
`default_nettype wire

// File: rtl/dmc_arbiter.sv
`default_nettype none
// ============================================================================
// dmc_arbiter : two-requester round-robin arbiter for the dual-bank controller
// Rev 1.0 : initial release
// ============================================================================
module dmc_arbiter
  import dmc_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  wire          clk,
  input  wire          rst_n,
  dmc_arbiter_if.slave bus
);

  dmc_state_e    r_state;
  logic          r_drain_done;
  logic          r_rr_ptr;

  logic          r_mem_select;
  logic          r_write_enable;
  logic          r_mem_cmd_valid;
  logic [AW-1:0] r_add_ex;
  logic [DW-1:0] r_data_ex;

  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic [DW-1:0] r_rsp0_rdata;
  logic [DW-1:0] r_rsp1_rdata;

  logic          w_grant_en;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any_gnt;
  logic          w_gnt_we;
  logic          w_gnt_bank;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic          w_ptr_hit;

  dmc_tag_t      w_load_tag;
  dmc_tag_t      w_ret_tag;
  logic          w_pipe_empty;

  // Ready must read 0 while reset is held, even if the state already says RUN.
  assign w_grant_en = rst_n & (r_state == ST_RUN) & ~bus.drain_req;
  assign w_gnt0     = w_grant_en & bus.req0_valid & (~bus.req1_valid | ~r_rr_ptr);
  assign w_gnt1     = w_grant_en & bus.req1_valid & (~bus.req0_valid |  r_rr_ptr);
  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_ptr_hit  = r_rr_ptr ? w_gnt1 : w_gnt0;

  assign w_gnt_we    = w_gnt1 ? bus.req1_we    : bus.req0_we;
  assign w_gnt_bank  = w_gnt1 ? bus.req1_bank  : bus.req0_bank;
  assign w_gnt_addr  = w_gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign w_gnt_wdata = w_gnt1 ? bus.req1_wdata : bus.req0_wdata;

  assign w_load_tag.valid = w_any_gnt & ~w_gnt_we;
  assign w_load_tag.id    = w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_drain_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.drain_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.drain_req) begin
            r_state <= ST_RUN;
          end else if (w_pipe_empty) begin
            r_state      <= ST_IDLE;
            r_drain_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!bus.drain_req) begin
            r_state      <= ST_RUN;
            r_drain_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_drain_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_ptr_hit) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

  // Address, data and bank hold between commands; only the strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_select    <= BANK_A;
      r_write_enable  <= 1'b0;
      r_mem_cmd_valid <= 1'b0;
      r_add_ex        <= '0;
      r_data_ex       <= '0;
    end else if (w_any_gnt) begin
      r_mem_select    <= w_gnt_bank;
      r_write_enable  <= w_gnt_we;
      r_mem_cmd_valid <= 1'b1;
      r_add_ex        <= w_gnt_addr;
      r_data_ex       <= w_gnt_wdata;
    end else begin
      r_write_enable  <= 1'b0;
      r_mem_cmd_valid <= 1'b0;
    end
  end

  dmc_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load_tag),
    .i_flush (1'b0),
    .o_tag   (w_ret_tag),
    .o_empty (w_pipe_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= w_ret_tag.valid & ~w_ret_tag.id;
      r_rsp1_valid <= w_ret_tag.valid &  w_ret_tag.id;
      if (w_ret_tag.valid & ~w_ret_tag.id) r_rsp0_rdata <= bus.mem_rdata;
      if (w_ret_tag.valid &  w_ret_tag.id) r_rsp1_rdata <= bus.mem_rdata;
    end
  end

  assign bus.req0_ready    = w_gnt0;
  assign bus.req1_ready    = w_gnt1;
  assign bus.rsp0_valid    = r_rsp0_valid;
  assign bus.rsp1_valid    = r_rsp1_valid;
  assign bus.rsp0_rdata    = r_rsp0_rdata;
  assign bus.rsp1_rdata    = r_rsp1_rdata;
  assign bus.mem_select    = r_mem_select;
  assign bus.write_enable  = r_write_enable;
  assign bus.mem_cmd_valid = r_mem_cmd_valid;
  assign bus.add_ex        = r_add_ex;
  assign bus.data_ex       = r_data_ex;
  assign bus.drain_done    = r_drain_done;

endmodule
`default_nettype wire

// File: tb/tb_dmc_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmc_arbiter : randomized and directed traffic against a transaction model
// Rev 1.0 : initial release
// ============================================================================
module tb_dmc_arbiter;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int RD_LAT = 2;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_IDLE  = 2;

  typedef struct {
    logic       we;
    logic       bank;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    int         id;
    int         due;
    logic [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmc_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dmc_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cmd_t       q0[$];
  cmd_t       q1[$];
  rsp_t       exp_q[$];
  logic [7:0] ref_mem [2][256];
  logic [7:0] env_mem [2][256];
  logic [7:0] env_pipe [RD_LAT+1];

  int   cyc, n_vec, n_err;
  int   m_mode;
  bit   m_ptr, m_done, m_cv, m_we, m_bank;
  logic [7:0] m_addr, m_data;
  bit   hold0, hold1, gaps_on;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); exp_q.delete();
    m_mode = M_RUN; m_ptr = 0; m_done = 0;
    m_cv = 0; m_we = 0; m_bank = 0; m_addr = 0; m_data = 0;
    hold0 = 0; hold1 = 0;
    for (int i = 0; i <= RD_LAT; i++) env_pipe[i] = 8'($urandom);
  endtask

  task automatic check_all_zero();
    check_eq("rst_ready0", bus.req0_ready, 0);
    check_eq("rst_ready1", bus.req1_ready, 0);
    check_eq("rst_rsp0_valid", bus.rsp0_valid, 0);
    check_eq("rst_rsp1_valid", bus.rsp1_valid, 0);
    check_eq("rst_rsp0_rdata", bus.rsp0_rdata, 0);
    check_eq("rst_rsp1_rdata", bus.rsp1_rdata, 0);
    check_eq("rst_mem_select", bus.mem_select, 0);
    check_eq("rst_write_enable", bus.write_enable, 0);
    check_eq("rst_data_ex", bus.data_ex, 0);
    check_eq("rst_add_ex", bus.add_ex, 0);
    check_eq("rst_mem_cmd_valid", bus.mem_cmd_valid, 0);
    check_eq("rst_drain_done", bus.drain_done, 0);
  endtask

  task automatic drive();
    bit v0, v1;
    v0 = (q0.size() > 0) && (hold0 || !gaps_on || ($urandom_range(3) != 0));
    v1 = (q1.size() > 0) && (hold1 || !gaps_on || ($urandom_range(3) != 0));
    hold0 = v0; hold1 = v1;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    if (v0) begin
      bus.req0_we = q0[0].we; bus.req0_bank = q0[0].bank;
      bus.req0_addr = q0[0].addr; bus.req0_wdata = q0[0].wdata;
    end else begin
      bus.req0_we = 1'($urandom); bus.req0_bank = 1'($urandom);
      bus.req0_addr = 8'($urandom); bus.req0_wdata = 8'($urandom);
    end
    if (v1) begin
      bus.req1_we = q1[0].we; bus.req1_bank = q1[0].bank;
      bus.req1_addr = q1[0].addr; bus.req1_wdata = q1[0].wdata;
    end else begin
      bus.req1_we = 1'($urandom); bus.req1_bank = 1'($urandom);
      bus.req1_addr = 8'($urandom); bus.req1_wdata = 8'($urandom);
    end
  endtask

  // Controller stand-in: writes land at the end of the command cycle,
  // read data appears RD_LAT cycles after the command, garbage otherwise.
  task automatic env_step();
    logic [7:0] d;
    d = 8'($urandom);
    if (bus.mem_cmd_valid && bus.write_enable)
      env_mem[bus.mem_select][bus.add_ex] = bus.data_ex;
    else if (bus.mem_cmd_valid)
      d = env_mem[bus.mem_select][bus.add_ex];
    for (int i = RD_LAT; i > 0; i--) env_pipe[i] = env_pipe[i-1];
    env_pipe[0] = d;
    bus.mem_rdata = env_pipe[RD_LAT];
  endtask

  task automatic eval_cycle();
    bit         e0, e1, v0, v1, drn;
    logic [7:0] d0, d1;
    rsp_t       r;
    cmd_t       c;
    int         id;
    e0 = 0; e1 = 0; d0 = 0; d1 = 0;
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      if (r.id == 0) begin e0 = 1; d0 = r.data; end
      else           begin e1 = 1; d1 = r.data; end
    end
    check_eq("rsp0_valid", bus.rsp0_valid, e0);
    check_eq("rsp1_valid", bus.rsp1_valid, e1);
    if (e0) check_eq("rsp0_rdata", bus.rsp0_rdata, d0);
    if (e1) check_eq("rsp1_rdata", bus.rsp1_rdata, d1);
    check_eq("mem_cmd_valid", bus.mem_cmd_valid, m_cv);
    check_eq("write_enable", bus.write_enable, m_we);
    check_eq("mem_select", bus.mem_select, m_bank);
    check_eq("add_ex", bus.add_ex, m_addr);
    check_eq("data_ex", bus.data_ex, m_data);
    check_eq("drain_done", bus.drain_done, m_done);

    v0 = bus.req0_valid; v1 = bus.req1_valid; drn = bus.drain_req;
    id = -1;
    if (m_mode == M_RUN && !drn) begin
      if (v0 && v1)  id = m_ptr ? 1 : 0;
      else if (v0)   id = 0;
      else if (v1)   id = 1;
    end
    check_eq("req0_ready", bus.req0_ready, id == 0);
    check_eq("req1_ready", bus.req1_ready, id == 1);

    if (id >= 0) begin
      if (id == (m_ptr ? 1 : 0)) m_ptr = !m_ptr;
      if (id == 0) begin c = q0.pop_front(); hold0 = 0; end
      else         begin c = q1.pop_front(); hold1 = 0; end
      m_cv = 1; m_we = c.we; m_bank = c.bank; m_addr = c.addr; m_data = c.wdata;
      if (c.we) ref_mem[c.bank][c.addr] = c.wdata;
      else begin
        r.id = id; r.due = cyc + 1 + RD_LAT + 1; r.data = ref_mem[c.bank][c.addr];
        exp_q.push_back(r);
      end
    end else begin
      m_cv = 0; m_we = 0;
    end

    case (m_mode)
      M_RUN:   if (drn) m_mode = M_DRAIN;
      M_DRAIN: if (!drn) m_mode = M_RUN;
               else if (exp_q.size() == 0) begin m_mode = M_IDLE; m_done = 1; end
      default: if (!drn) begin m_mode = M_RUN; m_done = 0; end
    endcase
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      drive();
      @(negedge clk);
      env_step();
      eval_cycle();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic run_until_quiet(input int max_cyc);
    int k;
    k = 0;
    while ((q0.size() + q1.size() + exp_q.size()) > 0 && k < max_cyc) begin
      run_cycles(1);
      k++;
    end
    run_cycles(2);
    check_eq("quiet_timeout", q0.size() + q1.size() + exp_q.size(), 0);
  endtask

  function automatic cmd_t mk(input bit we, input bit bank, input logic [7:0] addr,
                              input logic [7:0] wdata);
    cmd_t c;
    c.we = we; c.bank = bank; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; gaps_on = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) begin
        ref_mem[b][a] = 8'((b * 37) + (a * 11) + 60);
        env_mem[b][a] = 8'((b * 37) + (a * 11) + 60);
      end
    model_reset();
    rst_n = 1'b0;
    bus.drain_req = 1'b0;
    bus.mem_rdata = 8'h00;
    q0.push_back(mk(0, 0, 8'h00, 8'h00));
    drive();
    #1;
    check_all_zero();
    q0.delete(); hold0 = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read, same bank A address
    q0.push_back(mk(1, 0, 8'h05, 8'hA5));
    q0.push_back(mk(0, 0, 8'h05, 8'h00));
    run_until_quiet(30);

    // Contention on bank B reads
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 1, 8'h10, 8'h00));
      q1.push_back(mk(0, 1, 8'h20, 8'h00));
    end
    run_until_quiet(40);

    // Bank isolation
    q1.push_back(mk(1, 0, 8'h03, 8'h11));
    q1.push_back(mk(1, 1, 8'h03, 8'h22));
    q1.push_back(mk(0, 0, 8'h03, 8'h00));
    q1.push_back(mk(0, 1, 8'h03, 8'h00));
    run_until_quiet(30);

    // Drain with two reads in flight and a request waiting
    q0.push_back(mk(0, 0, 8'h40, 8'h00));
    q0.push_back(mk(0, 1, 8'h41, 8'h00));
    run_cycles(2);
    q0.push_back(mk(0, 0, 8'h42, 8'h00));
    bus.drain_req = 1'b1;
    run_cycles(8);
    bus.drain_req = 1'b0;
    run_until_quiet(30);

    // Back-to-back write/read at 0xFF from requester 1
    for (int i = 0; i < 4; i++) begin
      q1.push_back(mk(1, 1, 8'hFF, 8'(8'h30 + i)));
      q1.push_back(mk(0, 1, 8'hFF, 8'h00));
    end
    run_until_quiet(40);

    // Reset with a read in flight
    q0.push_back(mk(0, 0, 8'h07, 8'h00));
    run_cycles(2);
    q0.push_back(mk(0, 0, 8'h08, 8'h00));
    drive();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycles(6);
    q0.push_back(mk(0, 0, 8'h09, 8'h00));
    q1.push_back(mk(0, 1, 8'h09, 8'h00));
    run_until_quiet(30);

    // Randomized traffic with occasional drains
    gaps_on = 1;
    for (int n = 0; n < 400; n++) begin
      if (q0.size() < 3 && $urandom_range(2) == 0)
        q0.push_back(mk(1'($urandom), 1'($urandom), 8'($urandom_range(3)), 8'($urandom)));
      if (q1.size() < 3 && $urandom_range(2) == 0)
        q1.push_back(mk(1'($urandom), 1'($urandom), 8'($urandom_range(3)), 8'($urandom)));
      if ($urandom_range(19) == 0) bus.drain_req = ~bus.drain_req;
      run_cycles(1);
    end
    bus.drain_req = 1'b0;
    run_until_quiet(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
